// File: rtl/password_writer_pkg.sv
// Shared lock definitions: writer FSM states and the widths that the validator
// and the password writer must agree on.
package password_writer_pkg;

    localparam int PW_DIGITS    = 4;
    localparam int PW_DIGIT_W   = 4;
    localparam int PW_ADDR_W    = 2;
    localparam int PW_MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTER,
        S_CONFIRM,
        S_WRITE
    } writer_state_t;

endpackage

// File: rtl/password_writer.sv
// Password programmer: collects a 4-digit code, requires an identical re-entry,
// then burns it into the password store with four back-to-back writes.
module password_writer
    import password_writer_pkg::*;
#(
    parameter int DIGIT_COUNT = PW_DIGITS,
    parameter int MAX_DIGIT   = PW_MAX_DIGIT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  authorized,
    input  logic                  start,
    input  logic                  cancel,
    input  logic                  enable,
    input  logic [PW_DIGIT_W-1:0] digit,
    output logic [PW_ADDR_W-1:0]  address,
    output logic [PW_DIGIT_W-1:0] wrData,
    output logic                  wrEn,
    output logic                  busy,
    output logic                  doneLight,
    output logic                  mismatchLight,
    output logic                  invalidLight
);

    localparam logic [PW_ADDR_W-1:0] LAST_IDX = PW_ADDR_W'(DIGIT_COUNT - 1);

    writer_state_t                         state_q, state_d;
    logic [PW_ADDR_W-1:0]                  index_q, index_d;
    logic [DIGIT_COUNT-1:0][PW_DIGIT_W-1:0] entry_q, entry_d;
    logic                                  match_q, match_d;
    logic [PW_ADDR_W-1:0]                  address_q, address_d;
    logic [PW_DIGIT_W-1:0]                 wr_data_q, wr_data_d;
    logic                                  wr_en_q, wr_en_d;
    logic                                  busy_q, busy_d;
    logic                                  done_q, done_d;
    logic                                  mismatch_q, mismatch_d;
    logic                                  invalid_q, invalid_d;

    logic                 abort;
    logic                 legal;
    logic                 digit_match;
    logic [PW_ADDR_W-1:0] next_idx;

    // Losing authorization while collecting digits is treated exactly like cancel.
    assign abort    = cancel || !authorized;
    assign legal    = (digit <= PW_DIGIT_W'(MAX_DIGIT));
    assign next_idx = index_q + PW_ADDR_W'(1);

    always_comb begin
        // NOTE: every next-state value gets a default here so no path infers a latch.
        state_d     = state_q;
        index_d     = index_q;
        entry_d     = entry_q;
        match_d     = match_q;
        address_d   = '0;
        wr_data_d   = '0;
        wr_en_d     = 1'b0;
        done_d      = done_q;
        mismatch_d  = mismatch_q;
        invalid_d   = 1'b0;
        digit_match = match_q && (digit == entry_q[index_q]);

        case (state_q)
            S_IDLE: begin
                if (start && authorized && !cancel) begin
                    state_d    = S_ENTER;
                    index_d    = '0;
                    entry_d    = '0;
                    done_d     = 1'b0;
                    mismatch_d = 1'b0;
                end
            end
            S_ENTER: begin
                if (abort) begin
                    state_d = S_IDLE;
                    index_d = '0;
                    entry_d = '0;
                end else if (enable) begin
                    if (!legal) begin
                        invalid_d = 1'b1;
                    end else begin
                        entry_d[index_q] = digit;
                        if (index_q == LAST_IDX) begin
                            state_d = S_CONFIRM;
                            index_d = '0;
                            match_d = 1'b1;
                        end else begin
                            index_d = next_idx;
                        end
                    end
                end
            end
            S_CONFIRM: begin
                if (abort) begin
                    state_d = S_IDLE;
                    index_d = '0;
                    entry_d = '0;
                end else if (enable) begin
                    if (!legal) begin
                        invalid_d = 1'b1;
                    end else if (index_q != LAST_IDX) begin
                        match_d = digit_match;
                        index_d = next_idx;
                    end else if (digit_match) begin
                        // Present word 0 now so the burst starts the very next cycle.
                        state_d   = S_WRITE;
                        index_d   = '0;
                        wr_en_d   = 1'b1;
                        address_d = '0;
                        wr_data_d = entry_q[0];
                    end else begin
                        state_d    = S_IDLE;
                        index_d    = '0;
                        entry_d    = '0;
                        mismatch_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (index_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    index_d = '0;
                    entry_d = '0;
                    done_d  = 1'b1;
                end else begin
                    index_d   = next_idx;
                    wr_en_d   = 1'b1;
                    address_d = next_idx;
                    wr_data_d = entry_q[next_idx];
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        // NOTE: the digit buffers are a handful of flops, so they are reset with the rest.
        if (!RST) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            entry_q    <= '0;
            match_q    <= 1'b1;
            address_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q    <= state_d;
            index_q    <= index_d;
            entry_q    <= entry_d;
            match_q    <= match_d;
            address_q  <= address_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            invalid_q  <= invalid_d;
        end
    end

    assign address       = address_q;
    assign wrData        = wr_data_q;
    assign wrEn          = wr_en_q;
    assign busy          = busy_q;
    assign doneLight     = done_q;
    assign mismatchLight = mismatch_q;
    assign invalidLight  = invalid_q;

endmodule

// File: tb/tb_password_writer.sv
// Directed bench for password_writer: expected store writes are queued as the
// confirm sequence is driven and popped by a monitor as wrEn cycles appear.
module tb_password_writer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       authorized = 1'b0;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] digit = 4'd0;
    logic [1:0] address;
    logic [3:0] wrData;
    logic       wrEn;
    logic       busy;
    logic       doneLight;
    logic       mismatchLight;
    logic       invalidLight;

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    logic [5:0] exp_q[$];

    password_writer dut (
        .CLK          (CLK),
        .RST          (RST),
        .authorized   (authorized),
        .start        (start),
        .cancel       (cancel),
        .enable       (enable),
        .digit        (digit),
        .address      (address),
        .wrData       (wrData),
        .wrEn         (wrEn),
        .busy         (busy),
        .doneLight    (doneLight),
        .mismatchLight(mismatchLight),
        .invalidLight (invalidLight)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        enable = 1'b1;
        digit  = d;
        step();
        enable = 1'b0;
        digit  = 4'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push_writes(input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic [3:0] d3);
        exp_q.push_back({2'd0, d0});
        exp_q.push_back({2'd1, d1});
        exp_q.push_back({2'd2, d2});
        exp_q.push_back({2'd3, d3});
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20 && busy !== 1'b0; i++) step();
        check(tag, busy, 1'b0);
    endtask

    // Scoreboard side: every write pops one expected word; idle bus must be zero.
    always @(negedge CLK) begin
        if (wrEn === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_wrEn", wrEn, 1'b0);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("wr_address", address, e[5:4]);
                check("wr_data", wrData, e[3:0]);
            end
        end else if (wrEn === 1'b0) begin
            check("idle_bus_zero", {address, wrData}, 6'd0);
        end
    end

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_busy", busy, 1'b0);
        check("rst_wrEn", wrEn, 1'b0);
        check("rst_lights", {doneLight, mismatchLight, invalidLight}, 3'b000);
        RST = 1'b1;
        authorized = 1'b1;
        step();

        // Successful program 5,2,7,1
        writes_seen = 0;
        pulse_start();
        check("prog_busy", busy, 1'b1);
        press(4'd5); press(4'd2); press(4'd7); press(4'd1);
        check("prog_no_early_write", writes_seen, 0);
        push_writes(4'd5, 4'd2, 4'd7, 4'd1);
        press(4'd5); press(4'd2); press(4'd7); press(4'd1);
        check("prog_first_wr_latency", {wrEn, address}, {1'b1, 2'd0});
        wait_idle("prog_idle");
        check("prog_write_count", writes_seen, 4);
        check("prog_done", {doneLight, mismatchLight}, 2'b10);
        check("prog_queue_drained", exp_q.size(), 0);

        // Confirmation mismatch: 1,2,3,4 vs 1,2,3,5
        writes_seen = 0;
        pulse_start();
        check("mm_done_cleared", doneLight, 1'b0);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        press(4'd1); press(4'd2); press(4'd3);
        check("mm_no_early_exit", {busy, mismatchLight}, 2'b10);
        press(4'd5);
        check("mm_lights", {busy, doneLight, mismatchLight}, 3'b001);
        repeat (3) step();
        check("mm_no_writes", writes_seen, 0);

        // Illegal digits in both entry and confirm phases
        writes_seen = 0;
        pulse_start();
        check("ill_mm_cleared", mismatchLight, 1'b0);
        press(4'd12);
        check("ill_pulse_high", invalidLight, 1'b1);
        step();
        check("ill_pulse_low", invalidLight, 1'b0);
        press(4'd3); press(4'd4); press(4'd5); press(4'd6);
        press(4'd3); press(4'd4);
        press(4'd15);
        check("ill_confirm_pulse", invalidLight, 1'b1);
        push_writes(4'd3, 4'd4, 4'd5, 4'd6);
        press(4'd5); press(4'd6);
        wait_idle("ill_idle");
        check("ill_write_count", writes_seen, 4);
        check("ill_done", doneLight, 1'b1);

        // Unauthorized start, stray enable, start+cancel collision
        authorized = 1'b0;
        pulse_start();
        check("unauth_busy", busy, 1'b0);
        check("unauth_done_kept", doneLight, 1'b1);
        press(4'd8);
        check("unauth_enable", {busy, invalidLight, wrEn}, 3'b000);
        authorized = 1'b1;
        cancel = 1'b1;
        pulse_start();
        cancel = 1'b0;
        check("start_cancel_busy", busy, 1'b0);
        check("start_cancel_done_kept", doneLight, 1'b1);

        // Cancel after two digits
        writes_seen = 0;
        pulse_start();
        press(4'd1); press(4'd2);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cancel_busy", busy, 1'b0);
        check("cancel_lights", {doneLight, mismatchLight}, 2'b00);

        // Authorization lost during confirm
        pulse_start();
        press(4'd6); press(4'd6); press(4'd6); press(4'd6);
        press(4'd6);
        authorized = 1'b0;
        step();
        check("deauth_confirm_busy", busy, 1'b0);
        authorized = 1'b1;
        repeat (2) step();
        check("abort_no_writes", writes_seen, 0);

        // Authorization lost during write: burst still completes
        writes_seen = 0;
        pulse_start();
        press(4'd9); press(4'd0); press(4'd1); press(4'd8);
        push_writes(4'd9, 4'd0, 4'd1, 4'd8);
        press(4'd9); press(4'd0); press(4'd1); press(4'd8);
        authorized = 1'b0;
        wait_idle("deauth_write_idle");
        authorized = 1'b1;
        check("deauth_write_count", writes_seen, 4);
        check("deauth_write_done", doneLight, 1'b1);

        // Reset asserted on the second write cycle
        writes_seen = 0;
        pulse_start();
        press(4'd3); press(4'd1); press(4'd4); press(4'd2);
        exp_q.push_back({2'd0, 4'd3});
        exp_q.push_back({2'd1, 4'd1});
        press(4'd3); press(4'd1); press(4'd4); press(4'd2);
        step();
        check("rstw_second_word", {wrEn, address}, {1'b1, 2'd1});
        RST = 1'b0;
        step();
        check("rstw_outputs", {wrEn, busy, address}, 4'd0);
        check("rstw_lights", {doneLight, mismatchLight, invalidLight}, 3'b000);
        RST = 1'b1;
        step();
        check("rstw_write_count", writes_seen, 2);
        check("final_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
